// File: rtl/riscv_mem_pkg.sv
// MEM stage shared definitions: funct3 access codes and FSM states.
// Imported by load_align and mem_stage.
package riscv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane extraction with sign/zero extension.
// Unknown funct3 codes return the full word.
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr, 3'b000} +: 8];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    unique case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LBU:  data = {24'h0, b};
      F3_LHU:  data = {16'h0, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data memory handshake and MEM/WB register.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage
  import riscv_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_reg,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_wstrb,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [XLEN-1:0]   mem_data,
  output logic [XLEN-1:0]   alu_result,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_exc,
`endif
  output logic              wb_mem_reg
);

  state_t            state;
  logic              is_mem;
  logic              misal;
  logic              go;
  logic [1:0]        lane;
  logic [31:0]       st_wdata;
  logic [3:0]        st_wstrb;
  logic [31:0]       ld_data;

  logic [XLEN-1:0]   req_addr;
  logic [2:0]        req_f3;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              req_we;
  logic [4:0]        req_rd;
  logic              req_rw;
  logic              req_mr;

  assign is_mem = ex_valid & (ex_mem_read | ex_mem_write);
  assign lane   = ex_alu_result[1:0];

  always_comb begin
    st_wdata = ex_rs2_data[31:0];
    st_wstrb = 4'b1111;
    unique case (ex_funct3)
      F3_SB: begin
        st_wdata = {4{ex_rs2_data[7:0]}};
        st_wstrb = 4'b0001 << lane;
      end
      F3_SH: begin
        st_wdata = {2{ex_rs2_data[15:0]}};
        st_wstrb = 4'b0011 << {lane[1], 1'b0};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic sz_b;
  logic sz_h;

  // Stores have no unsigned codes, so 100/101 are word-sized for them.
  always_comb begin
    if (ex_mem_write) begin
      sz_b = (ex_funct3 == F3_SB);
      sz_h = (ex_funct3 == F3_SH);
    end else begin
      sz_b = (ex_funct3 == F3_LB) | (ex_funct3 == F3_LBU);
      sz_h = (ex_funct3 == F3_LH) | (ex_funct3 == F3_LHU);
    end
    misal = is_mem & ((sz_h & lane[0]) | (~sz_b & ~sz_h & |lane));
  end
`else
  assign misal = 1'b0;
`endif

  assign go         = is_mem & ~misal;
  assign stall      = (state == IDLE) ? go : ~dmem_ready;
  assign dmem_req   = (state == BUSY);
  assign dmem_we    = req_we;
  assign dmem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
  assign dmem_wdata = req_wdata;
  assign dmem_wstrb = req_wstrb;

  load_align u_align (
    .rdata  (dmem_rdata),
    .addr   (req_addr[1:0]),
    .funct3 (req_f3),
    .data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_addr     <= '0;
      req_f3       <= '0;
      req_wdata    <= '0;
      req_wstrb    <= '0;
      req_we       <= 1'b0;
      req_rd       <= '0;
      req_rw       <= 1'b0;
      req_mr       <= 1'b0;
      wb_valid     <= 1'b0;
      mem_data     <= '0;
      alu_result   <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_mem_reg   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            req_addr  <= ex_alu_result;
            req_f3    <= ex_funct3;
            req_wdata <= st_wdata;
            req_wstrb <= st_wstrb;
            req_we    <= ex_mem_write;
            req_rd    <= ex_rd;
            req_rw    <= ex_reg_write & ~ex_mem_write;
            req_mr    <= ex_mem_reg;
            wb_valid  <= 1'b0;
            state     <= BUSY;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_exc <= 1'b0;
`endif
          end else begin
            wb_valid     <= ex_valid;
            alu_result   <= ex_alu_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write & ~misal;
            wb_mem_reg   <= ex_mem_reg;
            mem_data     <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_exc <= misal;
`endif
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            wb_valid     <= 1'b1;
            alu_result   <= req_addr;
            wb_rd        <= req_rd;
            wb_reg_write <= req_rw;
            wb_mem_reg   <= req_mr;
            mem_data     <= req_we ? '0 : XLEN'(ld_data);
            state        <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage.
// Honors MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_reg;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [31:0] mem_data;
  logic [31:0] alu_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_mem_reg;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_reg    (ex_mem_reg),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .stall         (stall),
    .wb_valid      (wb_valid),
    .mem_data      (mem_data),
    .alu_result    (alu_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_exc  (misalign_exc),
`endif
    .wb_mem_reg    (wb_mem_reg)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: access width 1/2/4 bytes from the op kind and funct3.
  function automatic int acc_size(input bit store, input logic [2:0] f3);
    if (store) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ld_ref(input logic [31:0] rd,
                                         input logic [31:0] a,
                                         input logic [2:0] f3);
    int sz = acc_size(1'b0, f3);
    int off;
    logic [31:0] v;
    if (sz == 4) return rd;
    off = (sz == 1) ? int'(a % 4) : int'((a % 4) / 2) * 2;
    v = rd >> (8 * off);
    if (sz == 1) v = v & 32'hFF;
    else v = v & 32'hFFFF;
    if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
    if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    return v;
  endfunction

  function automatic logic [3:0] strb_ref(input logic [31:0] a,
                                          input logic [2:0] f3);
    int sz = acc_size(1'b1, f3);
    if (sz == 1) return 4'(1 << (a % 4));
    if (sz == 2) return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] wdata_ref(input logic [31:0] d,
                                            input logic [2:0] f3);
    int sz = acc_size(1'b1, f3);
    if (sz == 1) return (d % 256) * 32'h01010101;
    if (sz == 2) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic bit misal_ref(input bit store, input logic [2:0] f3,
                                   input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (a % acc_size(store, f3)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic run_op(input bit v, input bit rd_op, input bit wr_op,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] rd,
                        input bit rw, input bit mr, input int dly,
                        input logic [31:0] rdat, output int sc);
    bit mem;
    bit mis;
    logic [31:0] exp_md;
    bit exp_rw;
    bit exp_v;
    mem = v & (rd_op | wr_op);
    mis = mem & misal_ref(wr_op, f3, a);
    ex_valid = v; ex_mem_read = rd_op; ex_mem_write = wr_op;
    ex_funct3 = f3; ex_alu_result = a; ex_rs2_data = rs2;
    ex_rd = rd; ex_reg_write = rw; ex_mem_reg = mr;
    dmem_ready = 1'b0;
    sc = 0;
    #1;
    if (mem && !mis) begin
      chk("stall_issue", stall, 1);
      chk("req_idle", dmem_req, 0);
      sc++;
      @(posedge clk); #1;
      for (int i = 0; i < dly; i++) begin
        chk("stall_wait", stall, 1);
        chk("wbv_wait", wb_valid, 0);
        sc++;
        @(posedge clk); #1;
      end
      dmem_ready = 1'b1;
      dmem_rdata = rdat;
      #1;
      chk("stall_ready", stall, 0);
      chk("req_busy", dmem_req, 1);
      chk("we", dmem_we, wr_op);
      chk("addr", dmem_addr, a & ~32'd3);
      if (wr_op) begin
        chk("wstrb", dmem_wstrb, strb_ref(a, f3));
        chk("wdata", dmem_wdata, wdata_ref(rs2, f3));
      end
      @(posedge clk); #1;
      dmem_ready = 1'b0;
      exp_md = wr_op ? 32'd0 : ld_ref(rdat, a, f3);
      exp_rw = rw & ~wr_op;
      exp_v = 1'b1;
    end else begin
      chk("stall_none", stall, 0);
      @(posedge clk); #1;
      exp_md = 32'd0;
      exp_rw = rw & ~mis;
      exp_v = v;
    end
    ex_valid = 1'b0;
    chk("req_done", dmem_req, 0);
    chk("wb_valid", wb_valid, exp_v);
    chk("alu_result", alu_result, a);
    chk("wb_rd", wb_rd, rd);
    chk("wb_reg_write", wb_reg_write, exp_rw);
    chk("wb_mem_reg", wb_mem_reg, mr);
    chk("mem_data", mem_data, exp_md);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("misalign_exc", misalign_exc, mis);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int sc;
    int kind;
    bit v;
    logic [2:0] f3;
    rst = 1'b1;
    ex_valid = 0; ex_alu_result = 0; ex_rs2_data = 0; ex_rd = 0;
    ex_reg_write = 0; ex_mem_reg = 0; ex_mem_read = 0;
    ex_mem_write = 0; ex_funct3 = 0; dmem_ready = 0; dmem_rdata = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_md", mem_data, 0);
    chk("rst_alu", alu_result, 0);
    chk("rst_rw", wb_reg_write, 0);
    rst = 1'b0;

    run_op(1, 0, 0, 3'd0, 32'h1234, 0, 5'd5, 1, 0, 0, 0, sc);
    chk("add_stall_cycles", sc, 0);

    run_op(1, 1, 0, 3'd0, 32'h103, 0, 5'd7, 1, 1, 3,
           32'h80FF_0000, sc);
    chk("lb_stall_cycles", sc, 4);
    chk("lb_data", mem_data, 32'hFFFF_FF80);

    run_op(1, 1, 0, 3'd5, 32'h202, 0, 5'd8, 1, 1, 1,
           32'hBEEF_1234, sc);
    chk("lhu_data", mem_data, 32'h0000_BEEF);
    run_op(1, 1, 0, 3'd1, 32'h202, 0, 5'd8, 1, 1, 0,
           32'hBEEF_1234, sc);
    chk("lh_data", mem_data, 32'hFFFF_BEEF);

    run_op(1, 0, 1, 3'd0, 32'h301, 32'hAB, 5'd9, 1, 0, 2, 0, sc);
    chk("sb_rw", wb_reg_write, 0);

    // Reset while a load is outstanding.
    ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0;
    ex_funct3 = 3'd2; ex_alu_result = 32'h400;
    @(posedge clk); #1;
    chk("rb_req", dmem_req, 1);
    rst = 1'b1; ex_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rb_req_after", dmem_req, 0);
    chk("rb_stall_after", stall, 0);
    chk("rb_wbv_after", wb_valid, 0);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_ready_stall", stall, 0);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    chk("idle_ready_wbv", wb_valid, 0);
    chk("idle_ready_req", dmem_req, 0);
    chk("idle_ready_md", mem_data, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    run_op(1, 1, 0, 3'd2, 32'h102, 0, 5'd3, 1, 1, 0, 0, sc);
    chk("mis_stall_cycles", sc, 0);
    chk("mis_exc", misalign_exc, 1);
    chk("mis_rw", wb_reg_write, 0);
`endif

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      v = ($urandom_range(0, 9) != 0);
      f3 = 3'($urandom_range(0, 7));
      run_op(v, kind == 1 || kind == 3, kind >= 2, f3, $urandom,
             $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), $urandom, sc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
